pp_accumulator: RTL and testbench

- Sequential stage directly downstream of the 16-bit partial-product combiner (8-bit X, Y<<4 and Z<<8 summed into 16-bit W).
- Takes one 16-bit combined product per accepted beat over a valid/ready handshake and accumulates a frame of products into a wide sum.
- At frame end, presents the sum, term count and status flags on a held output handshake, for use in multiply-accumulate and dot-product paths.

---
 rtl/pp_accumulator.sv | 221 ++++++++++++++++++++++
 tb/tb_pp_accumulator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// ============================================================================
// Module   : pp_accumulator
// Purpose  : Frame accumulator placed after the 16-bit partial-product
//            combiner. Each accepted beat carries one unsigned 16-bit
//            product W. Beats are summed into an ACC_W-bit accumulator until
//            the frame closes. A frame closes on in_last_i, or when the term
//            count reaches its ceiling. The sum, the term count and the
//            status flags are then presented on a held output handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    :
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   clr_i         synchronous abort of the partial frame and any held result
//   in_valid_i    in_data_i / in_last_i are valid
//   in_ready_o    block can accept a beat (combinational)
//   in_data_i     16-bit unsigned product W
//   in_last_i     beat is the final term of the frame
//   out_valid_o   result is pending
//   out_ready_i   consumer accepts the result
//   out_data_o    frame sum (ACC_W bits)
//   out_count_o   number of terms in the frame (CNT_W bits)
//   out_ovf_o     frame overflowed ACC_W at least once
//   out_trunc_o   frame was auto-closed at the count ceiling without in_last
// Parameters:
//   ACC_W     accumulator / result width (>= 16)
//   CNT_W     term-counter width; at most 2^CNT_W - 1 terms per frame
//   SATURATE  0 = wrap modulo 2^ACC_W, 1 = clamp to all-ones on overflow
// ============================================================================
`default_nettype none

module pp_accumulator #(
  parameter int          ACC_W    = 24,
  parameter int          CNT_W    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_ovf_o,
  output logic             out_trunc_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (ACC_W < 16) begin : g_acc_w_check
    $error("pp_accumulator: ACC_W must be at least 16");
  end

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pp_accumulator: CNT_W must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // All-ones count is the ceiling: the beat that reaches it closes the frame.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_q,       ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q,  out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q,   out_ovf_d;
  logic               out_trunc_q, out_trunc_d;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic               beat_acc;
  logic [ACC_W:0]     sum_wide;
  logic               carry;
  logic [ACC_W-1:0]   acc_add;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_limit;
  logic               ovf_acc;
  logic               frame_close;
  logic               out_hs;

  // Ready never looks at in_valid_i, so upstream may wait on it freely.
  assign in_ready_o = (state_q == ST_ACC) && !clr_i;
  assign beat_acc   = in_valid_i && in_ready_o;

  // One extra bit captures the carry-out of the ACC_W-bit add.
  assign sum_wide = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_data_i};
  assign carry    = sum_wide[ACC_W];

  if (SATURATE != 0) begin : g_saturate
    // Once clamped, every later add either carries again or adds zero, so
    // the accumulator stays at all-ones for the rest of the frame.
    assign acc_add = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end else begin : g_wrap
    assign acc_add = sum_wide[ACC_W-1:0];
  end

  assign cnt_inc     = cnt_q + CNT_ONE;
  assign cnt_limit   = (cnt_inc == CNT_MAX);
  assign ovf_acc     = ovf_q | carry;
  assign frame_close = beat_acc && (in_last_i || cnt_limit);
  assign out_hs      = out_valid_q && out_ready_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    if (clr_i) begin
      // Abort wins over any beat or handshake. The result fields are left
      // as they are because they carry no meaning while out_valid is low.
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (frame_close) begin
            out_data_d  = acc_add;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_acc;
            // A close without in_last can only come from the count ceiling.
            out_trunc_d = !in_last_i;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else if (beat_acc) begin
            acc_d = acc_add;
            cnt_d = cnt_inc;
            ovf_d = ovf_acc;
          end
        end

        ST_HOLD: begin
          // The result fields keep their values after the handshake; the
          // cycle spent returning to ACC is the one bubble per frame.
          if (out_hs) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end

        default: begin
          state_d     = ST_ACC;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_trunc_o = out_trunc_q;

endmodule : pp_accumulator

`default_nettype wire

// File: tb/tb_pp_accumulator.sv
// ============================================================================
// Module   : tb_pp_accumulator
// Purpose  : Directed self-checking bench for pp_accumulator. Four instances
//            cover the default build, 16-bit wrap, 16-bit saturate and a
//            2-bit term counter. All four share the clock and reset, and each
//            instance has its own handshake inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_accumulator;

  logic clk;
  logic rst_n;

  // Per-instance stimulus: index 0 default, 1 wrap16, 2 sat16, 3 cnt2.
  logic [3:0]       vld;
  logic [3:0]       lst;
  logic [3:0]       clr;
  logic [3:0]       ordy;
  logic [3:0][15:0] dat;

  wire  [3:0]       rdy;
  wire  [3:0]       ov;
  wire  [3:0]       ovf;
  wire  [3:0]       trn;
  wire  [3:0][23:0] od;
  wire  [3:0][7:0]  oc;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pp_accumulator #(.ACC_W(24), .CNT_W(8), .SATURATE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .in_valid_i(vld[0]),
    .in_ready_o(rdy[0]), .in_data_i(dat[0]), .in_last_i(lst[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_data_o(od[0]),
    .out_count_o(oc[0]), .out_ovf_o(ovf[0]), .out_trunc_o(trn[0])
  );

  pp_accumulator #(.ACC_W(16), .CNT_W(8), .SATURATE(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .in_valid_i(vld[1]),
    .in_ready_o(rdy[1]), .in_data_i(dat[1]), .in_last_i(lst[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_data_o(od[1][15:0]),
    .out_count_o(oc[1]), .out_ovf_o(ovf[1]), .out_trunc_o(trn[1])
  );
  assign od[1][23:16] = 8'h00;

  pp_accumulator #(.ACC_W(16), .CNT_W(8), .SATURATE(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .in_valid_i(vld[2]),
    .in_ready_o(rdy[2]), .in_data_i(dat[2]), .in_last_i(lst[2]),
    .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .out_data_o(od[2][15:0]),
    .out_count_o(oc[2]), .out_ovf_o(ovf[2]), .out_trunc_o(trn[2])
  );
  assign od[2][23:16] = 8'h00;

  pp_accumulator #(.ACC_W(24), .CNT_W(2), .SATURATE(0)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[3]), .in_valid_i(vld[3]),
    .in_ready_o(rdy[3]), .in_data_i(dat[3]), .in_last_i(lst[3]),
    .out_valid_o(ov[3]), .out_ready_i(ordy[3]), .out_data_o(od[3]),
    .out_count_o(oc[3][1:0]), .out_ovf_o(ovf[3]), .out_trunc_o(trn[3])
  );
  assign oc[3][7:2] = 6'd0;

  // Presents one beat and returns at posedge+1 after it is accepted.
  // Entered and left at posedge+1, so consecutive calls are back-to-back.
  task automatic beat(input int idx, input logic [15:0] d, input logic last);
    bit done;
    done     = 1'b0;
    vld[idx] = 1'b1;
    dat[idx] = d;
    lst[idx] = last;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (rdy[idx]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout dut%0d: beat %h not accepted within 40 cycles", idx, d);
    end
    vld[idx] = 1'b0;
    lst[idx] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 6;
    if (rdy[0] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy[0]); end
    if (ov[0] !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov[0]); end
    if (od[0] !== 24'h0)  begin errors++; $display("FAIL reset_out_data: got %h expected 000000", od[0]); end
    if (oc[0] !== 8'h0)   begin errors++; $display("FAIL reset_out_count: got %0d expected 0", oc[0]); end
    if (ovf[0] !== 1'b0)  begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", ovf[0]); end
    if (trn[0] !== 1'b0)  begin errors++; $display("FAIL reset_out_trunc: got %b expected 0", trn[0]); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    ordy[0] = 1'b1;
    beat(0, 16'h0102, 1'b0);
    beat(0, 16'h0304, 1'b0);
    beat(0, 16'hFFFF, 1'b1);
    @(negedge clk);
    checks += 6;
    if (ov[0] !== 1'b1)        begin errors++; $display("FAIL basic_valid: got %b expected 1", ov[0]); end
    if (od[0] !== 24'h010405)  begin errors++; $display("FAIL basic_data: got %h expected 010405", od[0]); end
    if (oc[0] !== 8'd3)        begin errors++; $display("FAIL basic_count: got %0d expected 3", oc[0]); end
    if (ovf[0] !== 1'b0)       begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf[0]); end
    if (trn[0] !== 1'b0)       begin errors++; $display("FAIL basic_trunc: got %b expected 0", trn[0]); end
    if (rdy[0] !== 1'b0)       begin errors++; $display("FAIL basic_ready_hold: got %b expected 0", rdy[0]); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks += 2;
    if (ov[0] !== 1'b0)  begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", ov[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1 ordy[0] = 1'b0;
  endtask

  task automatic test_wrap_sat();
    logic [15:0] exp_d;
    for (int idx = 1; idx <= 2; idx++) begin
      exp_d = (idx == 1) ? 16'h0001 : 16'hFFFF;
      beat(idx, 16'hFFFF, 1'b0);
      beat(idx, 16'h0002, 1'b1);
      @(negedge clk);
      checks += 3;
      if (ov[idx] !== 1'b1)             begin errors++; $display("FAIL ovf_valid dut%0d: got %b expected 1", idx, ov[idx]); end
      if (od[idx] !== {8'h00, exp_d})   begin errors++; $display("FAIL ovf_data dut%0d: got %h expected %h", idx, od[idx], exp_d); end
      if (ovf[idx] !== 1'b1)            begin errors++; $display("FAIL ovf_flag dut%0d: got %b expected 1", idx, ovf[idx]); end
      ordy[idx] = 1'b1;
      @(posedge clk);
      #1 ordy[idx] = 1'b0;
      beat(idx, 16'h0005, 1'b1);
      @(negedge clk);
      checks += 3;
      if (od[idx] !== 24'h000005) begin errors++; $display("FAIL ovf_next_data dut%0d: got %h expected 000005", idx, od[idx]); end
      if (ovf[idx] !== 1'b0)      begin errors++; $display("FAIL ovf_next_flag dut%0d: got %b expected 0", idx, ovf[idx]); end
      if (oc[idx] !== 8'd1)       begin errors++; $display("FAIL ovf_next_count dut%0d: got %0d expected 1", idx, oc[idx]); end
      ordy[idx] = 1'b1;
      @(posedge clk);
      #1 ordy[idx] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    ordy[0] = 1'b0;
    beat(0, 16'h0010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 3;
      if (ov[0] !== 1'b1)       begin errors++; $display("FAIL bp_valid cyc%0d: got %b expected 1", c, ov[0]); end
      if (od[0] !== 24'h000010) begin errors++; $display("FAIL bp_data cyc%0d: got %h expected 000010", c, od[0]); end
      if (rdy[0] !== 1'b0)      begin errors++; $display("FAIL bp_ready cyc%0d: got %b expected 0", c, rdy[0]); end
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ov[0] !== 1'b0)  begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", ov[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_trunc();
    ordy[3] = 1'b1;
    beat(3, 16'd1, 1'b0);
    beat(3, 16'd2, 1'b0);
    beat(3, 16'd3, 1'b0);
    @(negedge clk);
    checks += 4;
    if (ov[3] !== 1'b1)       begin errors++; $display("FAIL trunc_valid: got %b expected 1", ov[3]); end
    if (od[3] !== 24'd6)      begin errors++; $display("FAIL trunc_data: got %h expected 000006", od[3]); end
    if (oc[3] !== 8'd3)       begin errors++; $display("FAIL trunc_count: got %0d expected 3", oc[3]); end
    if (trn[3] !== 1'b1)      begin errors++; $display("FAIL trunc_flag: got %b expected 1", trn[3]); end
    @(posedge clk);
    #1;
    beat(3, 16'd4, 1'b1);
    @(negedge clk);
    checks += 3;
    if (od[3] !== 24'd4)      begin errors++; $display("FAIL trunc_next_data: got %h expected 000004", od[3]); end
    if (oc[3] !== 8'd1)       begin errors++; $display("FAIL trunc_next_count: got %0d expected 1", oc[3]); end
    if (trn[3] !== 1'b0)      begin errors++; $display("FAIL trunc_next_flag: got %b expected 0", trn[3]); end
    @(posedge clk);
    #1 ordy[3] = 1'b0;
  endtask

  task automatic test_clr();
    ordy[0] = 1'b1;
    beat(0, 16'h1000, 1'b0);
    beat(0, 16'h2000, 1'b0);
    vld[0] = 1'b1;
    dat[0] = 16'h0007;
    clr[0] = 1'b1;
    @(negedge clk);
    checks += 1;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", rdy[0]); end
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    vld[0] = 1'b0;
    beat(0, 16'h0001, 1'b1);
    @(negedge clk);
    checks += 3;
    if (ov[0] !== 1'b1)       begin errors++; $display("FAIL clr_valid: got %b expected 1", ov[0]); end
    if (od[0] !== 24'h000001) begin errors++; $display("FAIL clr_data: got %h expected 000001", od[0]); end
    if (oc[0] !== 8'd1)       begin errors++; $display("FAIL clr_count: got %0d expected 1", oc[0]); end
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    // Abort while a result is held.
    beat(0, 16'h0033, 1'b1);
    clr[0] = 1'b1;
    @(posedge clk);
    #1 clr[0] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ov[0] !== 1'b0)  begin errors++; $display("FAIL clr_hold_valid: got %b expected 0", ov[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL clr_hold_ready: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    ordy[0] = 1'b0;
    beat(0, 16'h0050, 1'b0);
    beat(0, 16'h0060, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (rdy[0] !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b expected 1", rdy[0]); end
    if (ov[0] !== 1'b0)   begin errors++; $display("FAIL rstmid_valid: got %b expected 0", ov[0]); end
    if (od[0] !== 24'h0)  begin errors++; $display("FAIL rstmid_data: got %h expected 000000", od[0]); end
    if (oc[0] !== 8'h0)   begin errors++; $display("FAIL rstmid_count: got %0d expected 0", oc[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(0, 16'h0077, 1'b1);
    @(negedge clk);
    checks += 1;
    if (ov[0] !== 1'b1)   begin errors++; $display("FAIL rsthold_pre_valid: got %b expected 1", ov[0]); end
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (ov[0] !== 1'b0)   begin errors++; $display("FAIL rsthold_valid: got %b expected 0", ov[0]); end
    if (od[0] !== 24'h0)  begin errors++; $display("FAIL rsthold_data: got %h expected 000000", od[0]); end
    if (oc[0] !== 8'h0)   begin errors++; $display("FAIL rsthold_count: got %0d expected 0", oc[0]); end
    if (ovf[0] !== 1'b0)  begin errors++; $display("FAIL rsthold_ovf: got %b expected 0", ovf[0]); end
    if (rdy[0] !== 1'b1)  begin errors++; $display("FAIL rsthold_ready: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(0, 16'h00AA, 1'b1);
    @(negedge clk);
    checks += 3;
    if (ov[0] !== 1'b1)       begin errors++; $display("FAIL rstnext_valid: got %b expected 1", ov[0]); end
    if (od[0] !== 24'h0000AA) begin errors++; $display("FAIL rstnext_data: got %h expected 0000AA", od[0]); end
    if (oc[0] !== 8'd1)       begin errors++; $display("FAIL rstnext_count: got %0d expected 1", oc[0]); end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = '0;
    lst   = '0;
    clr   = '0;
    ordy  = '0;
    dat   = '0;
    test_reset();
    test_basic();
    test_wrap_sat();
    test_backpressure();
    test_trunc();
    test_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pp_accumulator

`default_nettype wire
